// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } if_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          PC_INC            = 1;

endpackage

// File: rtl/if_imem.sv
// Instruction memory: one synchronous write port, one synchronous read port
// with read enable so the read register holds between fetches. No reset.
module if_imem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, instruction memory, loader port and IDLE/LOAD/RUN/HALT control.
// Define IF_STEP_EN to add the i_step single-step input.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter  int                DATA_W    = 32,
  parameter  int                DEPTH     = 64,
  parameter  logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT),
  localparam int                ADDR_W    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_jump,
  input  logic [DATA_W-1:0] i_jump_addr,
`ifdef IF_STEP_EN
  input  logic              i_step,
`endif
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_pc_next,
  output logic              o_valid,
  output logic              o_halted,
  output logic              o_loading,
  output logic              o_fetch_err
);

  localparam logic [DATA_W-1:0] LAST_PC = DATA_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] MEM_TOP = DATA_W'(DEPTH);

  function automatic logic [DATA_W-1:0] pc_wrap(input logic [DATA_W-1:0] pc);
    pc_wrap = (pc == LAST_PC) ? '0 : pc + DATA_W'(PC_INC);
  endfunction

  if_state_e         state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              seen_q, seen_d;
  logic              mem_we, mem_re, step_go;
  logic [DATA_W-1:0] rdata;

`ifdef IF_STEP_EN
  assign step_go = i_step;
`else
  assign step_go = 1'b1;
`endif

  // Loader writes are dropped on a reset edge and are not accepted in HALT.
  assign mem_we = i_load_en && (state_q != HALT) && !i_rst;

  if_imem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_imem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_re    (mem_re),
    .i_raddr (fetch_pc_q[ADDR_W-1:0]),
    .o_rdata (rdata)
  );

  // The RAM read register has no reset, so o_instr reads 0 until a first fetch.
  assign o_instr = seen_q ? rdata : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    seen_d     = seen_q;
    mem_re     = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        valid_d = 1'b0;
        if (i_load_en) begin
          state_d = LOAD;
        end else if (i_start) begin
          state_d    = RUN;
          fetch_pc_d = '0;
        end
      end
      LOAD: begin
        valid_d = 1'b0;
        if (!i_load_en) state_d = IDLE;
      end
      RUN: begin
        if (i_load_en) begin
          state_d    = LOAD;
          fetch_pc_d = '0;
          valid_d    = 1'b0;
        end else if (valid_q && (o_instr == HALT_WORD)) begin
          // Halt word was presented last cycle; stop without fetching further.
          state_d = HALT;
          valid_d = 1'b0;
        end else if (i_jump) begin
          valid_d = 1'b0;
          if (i_jump_addr < MEM_TOP) begin
            fetch_pc_d = i_jump_addr;
          end else begin
            fetch_pc_d = '0;
            err_d      = 1'b1;
          end
        end else if (i_flush) begin
          valid_d = 1'b0;
        end else if (!i_stall && step_go) begin
          mem_re     = 1'b1;
          seen_d     = 1'b1;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = pc_wrap(fetch_pc_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_pc_next   = pc_wrap(pc_q);
  assign o_valid     = valid_q;
  assign o_fetch_err = err_q;
  assign o_halted    = (state_q == HALT);
  assign o_loading   = (state_q == LOAD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (DEPTH = 64).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;
`ifdef IF_STEP_EN
  logic        step = 1'b1;
`endif
  logic [31:0] instr, pc, pc_next;
  logic        valid, halted, loading, fetch_err;

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit #(.DATA_W(32), .DEPTH(64)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_load_en   (load_en),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_stall     (stall),
    .i_flush     (flush),
    .i_jump      (jump),
    .i_jump_addr (jump_addr),
`ifdef IF_STEP_EN
    .i_step      (step),
`endif
    .o_instr     (instr),
    .o_pc        (pc),
    .o_pc_next   (pc_next),
    .o_valid     (valid),
    .o_halted    (halted),
    .o_loading   (loading),
    .o_fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string name, input logic [31:0] epc, input logic [31:0] einstr);
    vectors++;
    if (valid !== 1'b1 || pc !== epc || instr !== einstr) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b pc=%0h instr=%0h, want valid=1 pc=%0h instr=%0h",
               name, valid, pc, instr, epc, einstr);
    end
  endtask

  task automatic start_run();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic test_reset();
    #20;
    vectors++;
    if ({valid, halted, loading, fetch_err} !== 4'b0 || pc !== 32'd0 || instr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v/h/l/e=%b pc=%0h instr=%0h, want 0000 0 0",
               {valid, halted, loading, fetch_err}, pc, instr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_all();
    for (int i = 0; i < 64; i++) begin
      load_en = 1'b1; load_addr = 6'(i); load_data = 32'h1000 + 32'(i);
      tick();
    end
    vectors++;
    if (loading !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_state: got loading=%0b valid=%0b, want 1 0", loading, valid);
    end
    load_en = 1'b0; tick();
    vectors++;
    if (loading !== 1'b0) begin
      miscompares++;
      $display("FAIL load_exit: got loading=%0b want 0", loading);
    end
  endtask

  task automatic test_wrap();
    int n;
    start_run();
    expect_fetch("wrap_first", 32'd0, 32'h1000);
    n = 0;
    while (pc !== 32'd62 && n < 70) begin tick(); n++; end
    expect_fetch("wrap_62", 32'd62, 32'h103E);
    tick();
    expect_fetch("wrap_63", 32'd63, 32'h103F);
    vectors++;
    if (pc_next !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_pc_next: got %0h want 0", pc_next);
    end
    tick();
    expect_fetch("wrap_0", 32'd0, 32'h1000);
    tick();
    expect_fetch("wrap_1", 32'd1, 32'h1001);
  endtask

  task automatic test_reset_midrun();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({valid, halted, loading, fetch_err} !== 4'b0 || pc !== 32'd0 || instr !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got v/h/l/e=%b pc=%0h instr=%0h, want 0000 0 0",
               {valid, halted, loading, fetch_err}, pc, instr);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_idle: got valid=%0b want 0", valid);
    end
    start_run();
    expect_fetch("retained_0", 32'd0, 32'h1000);
    tick();
    expect_fetch("retained_1", 32'd1, 32'h1001);
  endtask

  task automatic test_load_midrun();
    logic [31:0] words [4];
    words = '{32'h11, 32'h22, 32'h33, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) tick();
    expect_fetch("pre_load_5", 32'd5, 32'h1005);
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 6'(i); load_data = words[i];
      tick();
      vectors++;
      if (loading !== 1'b1 || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrun_load_%0d: got loading=%0b valid=%0b, want 1 0", i, loading, valid);
      end
    end
    load_en = 1'b0; tick();
    start_run();
    for (int i = 0; i < 4; i++) begin
      expect_fetch($sformatf("halt_seq_%0d", i), 32'(i), words[i]);
      tick();
    end
    vectors++;
    if (halted !== 1'b1 || valid !== 1'b0 || pc !== 32'd3 || instr !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL halt_state: got halted=%0b valid=%0b pc=%0h instr=%0h, want 1 0 3 ffffffff",
               halted, valid, pc, instr);
    end
    jump = 1'b1; jump_addr = 32'd10; tick();
    jump = 1'b0;
    vectors++;
    if (halted !== 1'b1 || valid !== 1'b0 || fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_ignores_jump: got halted=%0b valid=%0b err=%0b, want 1 0 0",
               halted, valid, fetch_err);
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; #2 rst = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 6'd3; load_data = 32'h44; tick();
    load_en = 1'b0; tick();
    start_run();
    expect_fetch("stall_pre0", 32'd0, 32'h11);
    tick();
    expect_fetch("stall_pre1", 32'd1, 32'h22);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_fetch($sformatf("stall_hold_%0d", i), 32'd1, 32'h22);
    end
    stall = 1'b0; tick();
    expect_fetch("stall_resume_2", 32'd2, 32'h33);
    tick();
    expect_fetch("stall_resume_3", 32'd3, 32'h44);
  endtask

  task automatic test_jump();
    stall = 1'b1; jump = 1'b1; jump_addr = 32'd10; tick();
    vectors++;
    if (valid !== 1'b0 || fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_bubble: got valid=%0b err=%0b, want 0 0", valid, fetch_err);
    end
    jump = 1'b0; stall = 1'b0; tick();
    expect_fetch("jump_target", 32'd10, 32'h100A);
    jump = 1'b1; jump_addr = 32'd70; tick();
    vectors++;
    if (valid !== 1'b0 || fetch_err !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_range: got valid=%0b err=%0b, want 0 1", valid, fetch_err);
    end
    jump = 1'b0; tick();
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_err_pulse: got err=%0b want 0", fetch_err);
    end
    expect_fetch("jump_range_pc0", 32'd0, 32'h11);
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; tick();
    vectors++;
    if (valid !== 1'b0 || pc !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_bubble: got valid=%0b pc=%0h, want 0 0", valid, pc);
    end
    flush = 1'b0; stall = 1'b0; tick();
    expect_fetch("flush_resume", 32'd1, 32'h22);
  endtask

`ifdef IF_STEP_EN
  task automatic test_step();
    logic [31:0] words [3];
    words = '{32'h11, 32'h22, 32'h33};
    rst = 1'b1; #2 rst = 1'b0;
    step = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      expect_fetch($sformatf("step_fetch_%0d", k), 32'(k), words[k]);
      for (int j = 0; j < 3; j++) tick();
      expect_fetch($sformatf("step_hold_%0d", k), 32'(k), words[k]);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_all();
    test_wrap();
    test_reset_midrun();
    test_load_midrun();
    test_stall();
    test_jump();
    test_flush();
`ifdef IF_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised IF stage for the MIPS pipeline: PC register, synchronous instruction memory, loader write port and a run-control FSM (IDLE/LOAD/RUN/HALT).
- Sits between the debug/loader unit (memory writes, start) and the IF/ID register.
- Jump redirects come from ID/EX; stall comes from the hazard unit.
- Single-edge (posedge) design with explicit halt detection, flush and out-of-range jump reporting.

Parameters:
- DATA_W, 32, instruction and PC width.
- DEPTH, 64, instruction memory words; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH), memory address width (localparam).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- i_clk  in  1  clock, posedge only
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  pulse: begin execution at PC 0 (from IDLE or HALT)
- i_load_en  in  1  loader write strobe
- i_load_addr  in  ADDR_W  loader word address
- i_load_data  in  DATA_W  loader word
- i_stall  in  1  hold fetch (hazard unit)
- i_flush  in  1  squash current fetch
- i_jump  in  1  redirect request
- i_jump_addr  in  DATA_W  redirect target (word address)
- o_instr  out  DATA_W  fetched instruction
- o_pc  out  DATA_W  address of o_instr
- o_pc_next  out  DATA_W  o_pc+1 with wrap (combinational from o_pc)
- o_valid  out  1  o_instr/o_pc valid for IF/ID
- o_halted  out  1  FSM in HALT
- o_loading  out  1  FSM in LOAD
- o_fetch_err  out  1  one-cycle pulse on out-of-range jump

Behaviour:
- Reset, asynchronous:
  - state = IDLE; fetch_pc, o_pc, o_instr, o_valid and o_fetch_err = 0.
  - Memory contents are retained, not cleared.
- Memory: synchronous write on posedge when i_load_en and state is IDLE, LOAD or RUN. Synchronous read of mem[fetch_pc].
- Read latency: 1 cycle. o_instr, o_pc and o_valid update together on the edge that consumes fetch_pc.
- IDLE:
  - i_load_en moves to LOAD; the write occurs the same cycle.
  - Otherwise i_start moves to RUN with fetch_pc = 0.
  - i_load_en has priority over i_start.
  - o_valid = 0.
- LOAD:
  - Write each cycle i_load_en = 1.
  - i_load_en = 0 returns to IDLE.
  - i_start is ignored.
  - o_valid = 0.
- RUN, priority order per cycle:
  1. i_load_en: go to LOAD, write the word, fetch_pc <= 0, o_valid <= 0.
  2. i_jump:
     - If i_jump_addr < DEPTH, fetch_pc <= i_jump_addr.
     - Otherwise fetch_pc <= 0 and o_fetch_err <= 1 for one cycle.
     - o_valid <= 0 (wrong-path bubble). Jump overrides stall and flush.
  3. i_flush: o_valid <= 0; fetch_pc held. Flush overrides stall.
  4. i_stall: all outputs and fetch_pc held.
  5. Normal:
     - o_instr <= mem[fetch_pc], o_pc <= fetch_pc, o_valid <= 1.
     - fetch_pc <= fetch_pc+1, wrapping DEPTH-1 to 0.
- Halt:
  - A normal fetch whose word equals HALT_WORD is presented with o_valid = 1 for that cycle; the state becomes HALT.
  - On the next edge o_valid <= 0, and o_pc and o_instr hold.
- HALT:
  - o_halted = 1.
  - i_load_en moves to LOAD (same priority as IDLE).
  - i_start moves to RUN with fetch_pc = 0.
  - i_stall, i_jump and i_flush are ignored.
- Loader writing the address being fetched in the same RUN cycle is impossible, because the load aborts RUN.
- Reset asserted mid-LOAD or mid-RUN returns to IDLE immediately. Writes in progress on that edge are dropped.

Optional Feature:
- IF_STEP_EN defined:
  - Adds port i_step (in, 1).
  - In RUN, a normal fetch occurs only on cycles with i_step = 1. i_step = 0 behaves as i_stall.
  - Jump, flush and load priorities are unchanged.
- Not defined: no i_step port; RUN fetches every unstalled cycle.

Decomposition:
- Package if_pkg holds:
  - state enum (IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3);
  - default HALT_WORD;
  - PC_INC = 1.
- One sub-module, if_imem: DEPTH x DATA_W RAM with one synchronous write port and one synchronous read port, no reset.
- FSM, PC and the output register live in instr_fetch_unit.

Test Plan:
- Reset mid-RUN (i_rst pulse between edges) -> outputs 0 immediately, state IDLE, previously loaded words still read back after restart.
- Load mem[0..3] = 0x11, 0x22, 0x33, HALT_WORD; pulse i_start -> o_valid pulses with (o_pc, o_instr) = (0, 0x11), (1, 0x22), (2, 0x33), (3, FFFFFFFF). Then o_halted = 1 and o_valid = 0.
- RUN with i_stall held 3 cycles at o_pc = 1 -> o_pc/o_instr frozen for 3 cycles, then the sequence resumes at o_pc = 2 with no skip or duplicate.
- i_jump with i_jump_addr = 10 while stalled -> one o_valid = 0 bubble, next valid o_pc = 10. i_jump_addr = 70 (DEPTH = 64) -> o_fetch_err for one cycle, next valid o_pc = 0.
- No halt word in memory, run 70 fetches -> o_pc sequence 62, 63, 0, 1 (wrap); o_pc_next = 0 when o_pc = 63.
- i_load_en mid-RUN at o_pc = 5 -> o_loading = 1, o_valid = 0. After load and i_start, fetch restarts at o_pc = 0 with the new data.
- IF_STEP_EN build: three i_step pulses spaced 4 cycles apart -> exactly 3 valid fetches, o_pc = 0, 1, 2.
